// File: rtl/acq_seq_pkg.sv
// Shared state encodings and default widths for the acquisition sequencer.
package acq_seq_pkg;

    typedef enum logic [1:0] {
        ST_IDLE        = 2'd0,
        ST_TRIGGER     = 2'd1,
        ST_WAIT_FRAME  = 2'd2,
        ST_WAIT_PERIOD = 2'd3
    } acq_state_t;

    localparam int ACQ_PERIOD_W_DEFAULT  = 32;
    localparam int ACQ_COUNT_W_DEFAULT   = 16;
    localparam int ACQ_TIMEOUT_W_DEFAULT = 24;

endpackage

// File: rtl/acq_down_counter.sv
// Loadable down counter that saturates at zero; used for the frame period and the watchdog.
module acq_down_counter #(
    parameter int WIDTH = 16
) (
    input  logic             master_clock,
    input  logic             reset,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    input  logic             enable,
    output logic             is_zero
);

    logic [WIDTH-1:0] count_reg;

    always_ff @(posedge master_clock) begin
        if (reset) begin
            count_reg <= '0;
        end else if (load) begin
            count_reg <= load_value;
        end else if (enable && (count_reg != '0)) begin
            count_reg <= count_reg - 1'b1;
        end
    end

    assign is_zero = (count_reg == '0);

endmodule

// File: rtl/acquisition_sequencer.sv
// Frame-level trigger/run controller for the S15611 acquisition path.
// Optional watchdog built only when ACQ_SEQ_WATCHDOG_EN is defined.
module acquisition_sequencer
    import acq_seq_pkg::*;
#(
    parameter int PERIOD_W  = ACQ_PERIOD_W_DEFAULT,
    parameter int COUNT_W   = ACQ_COUNT_W_DEFAULT,
    parameter int TIMEOUT_W = ACQ_TIMEOUT_W_DEFAULT
) (
    input  logic                 master_clock,
    input  logic                 reset,
    input  logic                 cmd_start,
    input  logic                 cmd_stop,
    input  logic [COUNT_W-1:0]   cfg_frame_count,
    input  logic [PERIOD_W-1:0]  cfg_period,
    input  logic [TIMEOUT_W-1:0] cfg_timeout,
    input  logic                 data_tvalid,
    input  logic                 data_tready,
    input  logic                 data_tlast,
    output logic                 frame_trigger,
    output logic                 acq_enable,
    output logic                 busy,
    output logic [COUNT_W-1:0]   frame_index,
    output logic                 timeout_err,
    output logic [3:0]           dbg_state
);

    acq_state_t          state_reg;
    acq_state_t          state_next;
    logic [COUNT_W-1:0]  count_shadow_reg;
    logic [PERIOD_W-1:0] period_shadow_reg;
    logic [COUNT_W-1:0]  frame_index_reg;
    logic [COUNT_W-1:0]  index_inc;
    logic                stop_pending_reg;
    logic                frame_trigger_reg;
    logic                acq_enable_reg;
    logic                busy_reg;
    logic [3:0]          dbg_state_reg;

    logic                completion;
    logic                frame_done;
    logic                run_done;
    logic                start_ok;
    logic                wd_expired;
    logic                period_zero;
    logic [PERIOD_W-1:0] period_src;
    logic [PERIOD_W-1:0] period_load;

    assign completion = data_tvalid & data_tready & data_tlast;
    assign frame_done = (state_reg == ST_WAIT_FRAME) && completion;
    assign index_inc  = frame_index_reg + 1'b1;
    assign start_ok   = cmd_start & ~cmd_stop;
    assign run_done   = ((count_shadow_reg != '0) && (index_inc == count_shadow_reg))
                        || stop_pending_reg || cmd_stop;

    // The first trigger of a run is scheduled while the shadows are still being latched.
    assign period_src  = (state_reg == ST_IDLE) ? cfg_period : period_shadow_reg;
    assign period_load = (period_src == '0) ? '0 : period_src - 1'b1;

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE: begin
                if (start_ok) state_next = ST_TRIGGER;
            end
            ST_TRIGGER: begin
                state_next = ST_WAIT_FRAME;
            end
            ST_WAIT_FRAME: begin
                if (frame_done) begin
                    if (run_done)         state_next = ST_IDLE;
                    else if (period_zero) state_next = ST_TRIGGER;
                    else                  state_next = ST_WAIT_PERIOD;
                end else if (wd_expired) begin
                    state_next = ST_IDLE;
                end
            end
            ST_WAIT_PERIOD: begin
                if (cmd_stop)         state_next = ST_IDLE;
                else if (period_zero) state_next = ST_TRIGGER;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // Loaded on entry to TRIGGER so the counter hits zero exactly one cycle before the next slot.
    acq_down_counter #(
        .WIDTH(PERIOD_W)
    ) u_period_counter (
        .master_clock(master_clock),
        .reset       (reset),
        .load        (state_next == ST_TRIGGER),
        .load_value  (period_load),
        .enable      (1'b1),
        .is_zero     (period_zero)
    );

`ifdef ACQ_SEQ_WATCHDOG_EN
    logic [TIMEOUT_W-1:0] timeout_shadow_reg;
    logic                 timeout_err_reg;
    logic                 wd_zero;

    acq_down_counter #(
        .WIDTH(TIMEOUT_W)
    ) u_watchdog (
        .master_clock(master_clock),
        .reset       (reset),
        .load        (state_reg == ST_TRIGGER),
        .load_value  (timeout_shadow_reg),
        .enable      (state_reg == ST_WAIT_FRAME),
        .is_zero     (wd_zero)
    );

    assign wd_expired = (state_reg == ST_WAIT_FRAME) && (timeout_shadow_reg != '0) && wd_zero;

    always_ff @(posedge master_clock) begin
        if (reset) begin
            timeout_shadow_reg <= '0;
            timeout_err_reg    <= 1'b0;
        end else if ((state_reg == ST_IDLE) && start_ok) begin
            timeout_shadow_reg <= cfg_timeout;
            timeout_err_reg    <= 1'b0;
        end else if (wd_expired && !frame_done) begin
            timeout_err_reg    <= 1'b1;
        end
    end

    assign timeout_err = timeout_err_reg;
`else
    logic unused_cfg_timeout;
    assign unused_cfg_timeout = ^cfg_timeout;
    assign wd_expired         = 1'b0;
    assign timeout_err        = 1'b0;
`endif

    always_ff @(posedge master_clock) begin
        if (reset) begin
            state_reg         <= ST_IDLE;
            count_shadow_reg  <= '0;
            period_shadow_reg <= '0;
            frame_index_reg   <= '0;
            stop_pending_reg  <= 1'b0;
            frame_trigger_reg <= 1'b0;
            acq_enable_reg    <= 1'b0;
            busy_reg          <= 1'b0;
            dbg_state_reg     <= 4'd0;
        end else begin
            state_reg         <= state_next;
            frame_trigger_reg <= (state_next == ST_TRIGGER);
            acq_enable_reg    <= (state_next == ST_TRIGGER) || (state_next == ST_WAIT_FRAME);
            busy_reg          <= (state_next != ST_IDLE);
            dbg_state_reg     <= 4'(state_next);

            if ((state_reg == ST_IDLE) && start_ok) begin
                count_shadow_reg  <= cfg_frame_count;
                period_shadow_reg <= cfg_period;
                frame_index_reg   <= '0;
            end else if (frame_done) begin
                frame_index_reg   <= index_inc;
            end

            // A stop during a frame is deferred so the packet in flight is never cut short.
            if (state_next == ST_IDLE) begin
                stop_pending_reg <= 1'b0;
            end else if (cmd_stop && ((state_reg == ST_TRIGGER) || (state_reg == ST_WAIT_FRAME))) begin
                stop_pending_reg <= 1'b1;
            end
        end
    end

    assign frame_trigger = frame_trigger_reg;
    assign acq_enable    = acq_enable_reg;
    assign busy          = busy_reg;
    assign frame_index   = frame_index_reg;
    assign dbg_state     = dbg_state_reg;

endmodule

// File: tb/tb_acquisition_sequencer.sv
// Randomized bench for acquisition_sequencer against an event-time reference model.
// Expectations follow ACQ_SEQ_WATCHDOG_EN the same way the design does.
module tb_acquisition_sequencer;

    localparam int PW = 16;
    localparam int CW = 4;
    localparam int TW = 12;
`ifdef ACQ_SEQ_WATCHDOG_EN
    localparam bit WD_EN = 1'b1;
`else
    localparam bit WD_EN = 1'b0;
`endif

    logic          master_clock = 1'b0;
    logic          reset;
    logic          cmd_start;
    logic          cmd_stop;
    logic [CW-1:0] cfg_frame_count;
    logic [PW-1:0] cfg_period;
    logic [TW-1:0] cfg_timeout;
    logic          data_tvalid;
    logic          data_tready;
    logic          data_tlast;
    logic          frame_trigger;
    logic          acq_enable;
    logic          busy;
    logic [CW-1:0] frame_index;
    logic          timeout_err;
    logic [3:0]    dbg_state;

    acquisition_sequencer #(
        .PERIOD_W (PW),
        .COUNT_W  (CW),
        .TIMEOUT_W(TW)
    ) dut (
        .master_clock   (master_clock),
        .reset          (reset),
        .cmd_start      (cmd_start),
        .cmd_stop       (cmd_stop),
        .cfg_frame_count(cfg_frame_count),
        .cfg_period     (cfg_period),
        .cfg_timeout    (cfg_timeout),
        .data_tvalid    (data_tvalid),
        .data_tready    (data_tready),
        .data_tlast     (data_tlast),
        .frame_trigger  (frame_trigger),
        .acq_enable     (acq_enable),
        .busy           (busy),
        .frame_index    (frame_index),
        .timeout_err    (timeout_err),
        .dbg_state      (dbg_state)
    );

    always #5 master_clock = ~master_clock;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    // Reference model: run/frame status plus absolute cycle times of triggers.
    bit m_run, m_open, m_stop_pend, m_err;
    int m_trig, m_next, m_index, m_count, m_period, m_timeout;

    int stim_dur;
    int trig_times[$];
    bit saw_wrap;
    int prev_idx;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, act, exp, cyc);
        end
    endtask

    task automatic model_edge(input bit rst, input bit st, input bit sp, input bit comp);
        int n;
        n = cyc;
        if (rst) begin
            m_run = 0; m_open = 0; m_stop_pend = 0; m_err = 0; m_index = 0;
        end else if (!m_run) begin
            if (st && !sp) begin
                m_count = int'(cfg_frame_count); m_period = int'(cfg_period);
                m_timeout = int'(cfg_timeout);
                m_index = 0; m_err = 0; m_stop_pend = 0;
                m_run = 1; m_open = 1; m_trig = n + 1;
            end
        end else if (m_open) begin
            if (sp) m_stop_pend = 1;
            if (comp && n > m_trig) begin
                m_index = (m_index + 1) % 16;
                if ((m_count != 0 && m_index == m_count) || m_stop_pend) begin
                    m_run = 0;
                end else begin
                    m_next = (m_trig + m_period > n + 1) ? m_trig + m_period : n + 1;
                    if (m_next == n + 1) m_trig = n + 1;
                    else m_open = 0;
                end
            end else if (WD_EN && m_timeout != 0 && n == m_trig + m_timeout + 1) begin
                m_err = 1; m_run = 0;
            end
        end else begin
            if (sp) m_run = 0;
            else if (n + 1 == m_next) begin m_open = 1; m_trig = n + 1; end
        end
        if (!m_run) begin m_open = 0; m_stop_pend = 0; end
    endtask

    task automatic step(input bit rst, input bit st, input bit sp, input bit v, input bit r, input bit l);
        int exp_state;
        @(negedge master_clock);
        reset = rst; cmd_start = st; cmd_stop = sp;
        data_tvalid = v; data_tready = r; data_tlast = l;
        @(posedge master_clock);
        model_edge(rst, st, sp, v & r & l);
        cyc++;
        #1;
        exp_state = !m_run ? 0 : (m_open ? ((m_trig == cyc) ? 1 : 2) : 3);
        check("frame_trigger", frame_trigger, (m_run && m_open && m_trig == cyc));
        check("acq_enable", acq_enable, (m_run && m_open));
        check("busy", busy, m_run);
        check("frame_index", frame_index, m_index);
        check("timeout_err", timeout_err, m_err);
        check("dbg_state", dbg_state, exp_state);
        if (frame_trigger === 1'b1) trig_times.push_back(cyc);
        if (prev_idx == 15 && frame_index == 4'd0 && busy) saw_wrap = 1;
        prev_idx = int'(frame_index);
    endtask

    task automatic cycle(input bit rst, input bit st, input bit sp);
        bit v, r, l;
        if (stim_dur >= 0 && m_run && m_open && cyc == m_trig + stim_dur) begin
            v = 1; r = 1; l = 1;
        end else if (stim_dur == -1) begin
            v = 1'($urandom_range(1)); r = 1'($urandom_range(1)); l = ($urandom_range(3) == 0);
        end else begin
            // Partial handshakes only: tlast without tready, tready without tlast.
            v = 1'($urandom_range(1)); l = 1'($urandom_range(1));
            r = (v && l) ? 1'b0 : 1'($urandom_range(1));
        end
        step(rst, st, sp, v, r, l);
    endtask

    task automatic stop_at(input bit in_frame);
        int guard;
        guard = 0;
        while (!(m_run && (in_frame ? (m_open && cyc == m_trig + 3) : !m_open)) && guard < 600) begin
            cycle(0, 0, 0);
            guard++;
        end
        check("stop_window_found", (guard < 600), 1);
        cycle(0, 0, 1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int idx_at_stop;
        reset = 1; cmd_start = 0; cmd_stop = 0;
        data_tvalid = 0; data_tready = 0; data_tlast = 0;
        cfg_frame_count = '0; cfg_period = '0; cfg_timeout = '0;
        m_run = 0; m_open = 0; m_stop_pend = 0; m_err = 0; m_index = 0;
        m_trig = 0; m_next = 0; m_count = 0; m_period = 0; m_timeout = 0;
        saw_wrap = 0; prev_idx = 0;
        stim_dur = -2;
        repeat (3) cycle(1, 0, 0);
        cycle(0, 0, 0);

        // Fixed count, long period: triggers every 100 clocks
        cfg_frame_count = 3; cfg_period = 100; cfg_timeout = 0; stim_dur = 40;
        cycle(0, 1, 0);
        trig_times.delete();
        trig_times.push_back(cyc);
        repeat (320) cycle(0, 0, 0);
        check("A_triggers", trig_times.size(), 3);
        if (trig_times.size() == 3) begin
            check("A_spacing1", trig_times[1] - trig_times[0], 100);
            check("A_spacing2", trig_times[2] - trig_times[1], 100);
        end
        check("A_index", frame_index, 3);

        // Frames longer than the period: retrigger one cycle after tlast
        cfg_frame_count = 4; cfg_period = 10; stim_dur = 25;
        trig_times.delete();
        cycle(0, 1, 0);
        repeat (130) cycle(0, 0, 0);
        check("B_triggers", trig_times.size(), 4);
        for (int i = 1; i < trig_times.size(); i++)
            check("B_spacing", trig_times[i] - trig_times[i-1], 26);

        // Continuous run, stop mid-frame then stop during the period wait
        cfg_frame_count = 0; cfg_period = 30; stim_dur = 12;
        cycle(0, 1, 0);
        repeat (70) cycle(0, 0, 0);
        stop_at(1);
        idx_at_stop = m_index;
        trig_times.delete();
        repeat (30) cycle(0, 0, 0);
        check("C_stop_frame_counted", frame_index, (idx_at_stop + 1) % 16);
        check("C_no_trigger_after_stop", trig_times.size(), 0);
        cycle(0, 1, 0);
        stop_at(0);
        check("C_stop_wait_idle", busy, 0);

        // Watchdog: no tlast at all
        cfg_frame_count = 2; cfg_timeout = 50; stim_dur = -2;
        cycle(0, 1, 0);
        repeat (60) cycle(0, 0, 0);
        check("D_timeout_err", timeout_err, WD_EN);
        check("D_busy", busy, !WD_EN);
        stim_dur = 5;
        cycle(0, 1, 0);
        check("D_err_cleared", timeout_err, 0);
        repeat (3) cycle(0, 0, 0);

        // Reset mid-frame, then start and stop together in IDLE
        cycle(1, 0, 0);
        check("E_reset_busy", busy, 0);
        check("E_reset_index", frame_index, 0);
        cycle(0, 1, 1);
        check("E_startstop_busy", busy, 0);
        check("E_startstop_trigger", frame_trigger, 0);

        // Start while busy is ignored and config is not re-latched
        cfg_frame_count = 2; cfg_period = 20; cfg_timeout = 0; stim_dur = 5;
        cycle(0, 1, 0);
        repeat (4) cycle(0, 0, 0);
        cfg_frame_count = 7; cfg_period = 3;
        cycle(0, 1, 0);
        trig_times.delete();
        repeat (60) cycle(0, 0, 0);
        check("F_triggers_after", trig_times.size(), 1);
        check("F_index", frame_index, 2);

        // Index wrap in a continuous run
        cfg_frame_count = 0; cfg_period = 2; stim_dur = 1;
        cycle(0, 1, 0);
        repeat (40) cycle(0, 0, 0);
        check("G_wrap_seen", saw_wrap, 1);
        cycle(0, 0, 1);
        repeat (5) cycle(0, 0, 0);
        check("G_stopped", busy, 0);

        // Random runs with random stream, commands and occasional reset
        stim_dur = -1;
        for (int run = 0; run < 30; run++) begin
            cfg_frame_count = 4'($urandom_range(5));
            cfg_period = 16'($urandom_range(40));
            cfg_timeout = ($urandom_range(2) == 0) ? 12'd0 : 12'($urandom_range(60, 5));
            cycle(0, 1, 0);
            for (int i = 0; i < 150; i++) begin
                if (i == 70) cfg_period = 16'($urandom_range(40));
                cycle(($urandom_range(999) < 3), ($urandom_range(999) < 20), ($urandom_range(999) < 10));
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/acquisition_sequencer.md
# acquisition_sequencer

Frame-level controller for the S15611 acquisition path. It starts sensor frames on a programmable start-to-start period and runs either a fixed number of frames or continuously. It counts completed frame packets by monitoring the AXI-Stream packet output, and flags frames that never complete. It sits between the PS control registers and the sensor driver/packetizer: it drives the frame trigger and the packetizer gate, and it observes the packet stream handshake.

## Interface
- `PERIOD_W`, default 32: width of the frame period, in clocks.
- `COUNT_W`, default 16: width of the frame count and the frame index.
- `TIMEOUT_W`, default 24: width of the watchdog timeout, in clocks.

Ports (name, direction, width, meaning):
- `master_clock` in 1: single 40 MHz clock.
- `reset` in 1: synchronous, active-high reset.
- `cmd_start` in 1: one-cycle pulse that starts a run.
- `cmd_stop` in 1: one-cycle pulse that ends a run gracefully.
- `cfg_frame_count` in COUNT_W: frames per run; 0 means continuous.
- `cfg_period` in PERIOD_W: start-to-start frame period, in clocks.
- `cfg_timeout` in TIMEOUT_W: per-frame watchdog, in clocks; 0 disables it.
- `data_tvalid`, `data_tready`, `data_tlast` in 1 each: monitor taps on the packet stream.
- `frame_trigger` out 1: one-cycle pulse requesting a sensor frame.
- `acq_enable` out 1: gate for the packetizer; high while a frame is outstanding.
- `busy` out 1: high whenever the state is not IDLE.
- `frame_index` out COUNT_W: frames completed in the current run.
- `timeout_err` out 1: sticky watchdog flag.
- `dbg_state` out 4: current state encoding.

## Operation
- Frame completion is defined as a cycle where `data_tvalid & data_tready & data_tlast` are all high.
- States: IDLE=0, TRIGGER=1, WAIT_FRAME=2, WAIT_PERIOD=3.
- IDLE:
  - On `cmd_start`: latch `cfg_*` into shadow registers, clear `frame_index` and `timeout_err`, go to TRIGGER.
  - `cfg_*` changes during a run have no effect until the next `cmd_start`.
- TRIGGER (one cycle):
  - `frame_trigger`=1.
  - Load the period counter with `period-1` and the watchdog with `timeout`.
  - Go to WAIT_FRAME.
- WAIT_FRAME:
  - Period counter and watchdog count down, saturating at 0. A watchdog loaded with 0 never expires.
  - On completion, `frame_index` += 1 (wraps modulo 2^COUNT_W). Then:
    - if count≠0 and the new index equals count, or a stop is pending → IDLE;
    - else if the period counter is 0 → TRIGGER;
    - else → WAIT_PERIOD.
  - Watchdog expiry, evaluated only while in WAIT_FRAME and only if no completion occurs in the same cycle: set `timeout_err`, do not increment the index, go to IDLE. Completion wins when both occur in the same cycle.
- WAIT_PERIOD: when the period counter reaches 0 → TRIGGER.
- `cmd_stop` handling:
  - In IDLE: ignored.
  - In WAIT_PERIOD: → IDLE on the next cycle, with no further trigger.
  - In TRIGGER or WAIT_FRAME: set `stop_pending`; the current frame finishes so packets are never truncated.
  - `stop_pending` is cleared on entry to IDLE.
- `cmd_start` and `cmd_stop` together in IDLE: stop wins and no run starts.
- `cmd_start` while busy: ignored.
- Output levels by state:
  - `acq_enable`=1 in TRIGGER and WAIT_FRAME, 0 otherwise.
  - `busy`=1 in every state except IDLE.
- Effective frame spacing = max(`cfg_period`, 2, frame duration + 1) clocks.

## Timing
- All outputs are registered.
- Reset values: state IDLE; `frame_trigger`=0, `acq_enable`=0, `busy`=0, `frame_index`=0, `timeout_err`=0, `dbg_state`=0.
- Reset has the same effect in every state, including mid-frame: the next cycle is IDLE with all outputs at their reset values, and `stop_pending` is cleared.
- `cmd_start` sampled at cycle N → `frame_trigger`, `acq_enable` and `busy` all high at N+1.
- Trigger at cycle T and frame completion before T+P-1, with P = `cfg_period` ≥ 2 → next trigger at T+P.
- Completion at cycle C with the period already elapsed → next trigger at C+1.
- `frame_index` updates at C+1.
- Final completion at C → `busy`=0 and `acq_enable`=0 at C+1.
- Watchdog: the trigger at T loads the timeout value L. Expiry is reached L+1 cycles after the trigger, so `timeout_err`=1 and `busy`=0 at T+L+2.

## Configuration
- Macro: `ACQ_SEQ_WATCHDOG_EN`.
- Defined: watchdog counter and `timeout_err` logic are built as described above.
- Undefined: no watchdog logic; `cfg_timeout` is ignored, `timeout_err` is tied to 0, and WAIT_FRAME waits indefinitely for completion.

## Structure
- Package `acq_seq_pkg` holds:
  - state encodings IDLE/TRIGGER/WAIT_FRAME/WAIT_PERIOD;
  - default values for `PERIOD_W`, `COUNT_W` and `TIMEOUT_W`.
- Sub-module `acq_down_counter`: a loadable, saturating down counter with a zero flag, parameterised by width. It is instantiated for the period counter and, under the macro, for the watchdog.

## Test plan
- Count=3, period=100, each frame completes 40 clocks after its trigger → triggers at cycles 1, 101, 201; `frame_index`=3; `busy` falls one cycle after the third tlast.
- Period=10, frames take 25 clocks → each trigger occurs one cycle after the previous tlast; no overlap; `acq_enable` never high for two outstanding frames.
- Continuous mode (count=0), `cmd_stop` issued mid-frame → that frame's tlast is still counted, then IDLE with no further trigger. `cmd_stop` in WAIT_PERIOD → IDLE next cycle.
- Timeout=50, no tlast ever arrives → `timeout_err`=1 and `busy`=0 at trigger+52. The next `cmd_start` clears `timeout_err`. With the macro undefined, the sequencer stays in WAIT_FRAME.
- `reset` asserted in WAIT_FRAME, and separately `cmd_start`+`cmd_stop` asserted together in IDLE → all outputs at reset values, no trigger. `cmd_start` while busy is ignored and the config is not re-latched.
- tlast without tready, and tready without tlast → neither is counted. A `COUNT_W`=4 continuous run wraps `frame_index` from 15 to 0.
